muldiv_hilo: RTL and testbench
==============================

# muldiv_hilo

Iterative multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core, parametrised in operand width. It sits in the EX stage beside the ALU. It accepts MULT/MULTU/DIV/DIVU plus direct MTHI/MTLO writes, runs one operation at a time over multiple cycles, and exposes a busy flag for the hazard logic to stall MFHI/MFLO and new multiply/divide issues.

## Interface
- WIDTH, 32, operand and HI/LO width; must be ≥4 and even.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  launch the operation in op using a, b; sampled only in IDLE.
- op  input  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
- a  input  WIDTH  rs operand (multiplicand / dividend).
- b  input  WIDTH  rt operand (multiplier / divisor).
- abort  input  1  flush; kills an in-flight operation, HI/LO unchanged.
- we_hi  input  1  MTHI write strobe; honoured only in IDLE.
- we_lo  input  1  MTLO write strobe; honoured only in IDLE.
- wd  input  WIDTH  MTHI/MTLO write data.
- busy  output  1  operation in flight (RUN or FIX).
- done  output  1  one-cycle pulse: HI/LO just updated by a completed operation.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

## Operation
- Reset: state IDLE; hi=0, lo=0, busy=0, done=0; internal counters and scratch cleared.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 (abort=0) latches |a|, |b| (absolute values for signed ops; raw for unsigned), the result-sign flags and op, then goes to RUN with count=0.
  - start together with we_hi/we_lo: the write happens, and the operation starts, overwriting HI/LO at completion.
  - start with abort=1 is ignored.
- RUN: one bit per cycle for WIDTH cycles; count goes 0..WIDTH-1, then FIX.
  - Multiply: shift-add over a 2·WIDTH product.
  - Divide: restoring, one quotient bit per cycle; remainder is WIDTH+1 bits internally.
- FIX, one cycle:
  - Apply sign correction. Product is negated if sign(a)≠sign(b). Quotient truncates toward zero. Remainder takes the dividend's sign.
  - Write hi/lo, then go to IDLE.
  - Multiply: hi=product[2W-1:W], lo=product[W-1:0]. Divide: hi=remainder, lo=quotient.
- Divide by zero (b=0): same latency; lo=all ones, hi=a unmodified for both DIV and DIVU.
- DIV of most-negative by −1: lo=most-negative value (e.g. 0x80000000), hi=0; no trap.
- abort in RUN or FIX: return to IDLE at the next edge; hi/lo untouched; no done pulse.
- start in RUN/FIX is ignored. The pipeline must not issue while busy=1.
- we_hi/we_lo in RUN/FIX are ignored. The hazard unit stalls MTHI/MTLO on busy.

## Timing
- start sampled at edge N → busy=1 from after edge N.
- RUN occupies edges N+1..N+WIDTH; FIX is evaluated at edge N+WIDTH+1.
- At edge N+WIDTH+1: hi/lo take the result, busy drops to 0, done=1 for that single cycle.
- Latency: WIDTH+1 cycles, start to result; identical for all ops, divide-by-zero included.
- Back-to-back: start may be asserted in the done cycle; the new op is accepted at that edge.
- MTHI/MTLO: hi/lo update at the sampling edge; visible the next cycle.
- hi/lo are stable between updates; read combinationally from registers.
- rst asserted mid-operation: immediate return to reset values; no done.

## Test plan
- Reset with WIDTH=32 and stimulus (start=1, MULT, a=5, b=3) held through release → hi=0, lo=0, busy=0 during reset; start sampled only after release.
- MULT a=0xFFFFFFFD (−3), b=5 → exactly 33 cycles later done=1, hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=100, b=0 → after 33 cycles lo=0xFFFFFFFF, hi=0x00000064.
- MTHI wd=0x1234 in IDLE → hi=0x1234 next cycle. Start MULTU 7×6, then at cycle 10 assert abort → busy=0 next cycle, hi=0x1234 unchanged, no done. Also drive we_lo during RUN → lo unchanged.
- Issue MULTU 7×6 and assert start again (DIVU 42/5) in the done cycle → first result hi=0, lo=42. Second op accepted with no gap; 33 cycles later lo=8, hi=2.

Source files
------------

// File: rtl/muldiv_hilo_if.sv
// rtl/muldiv_hilo_if.sv - EX-stage multiply/divide request and HI/LO bus
interface muldiv_hilo_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             abort;
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] wd;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, abort, we_hi, we_lo, wd,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, abort, we_hi, we_lo, wd,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO pair
module muldiv_hilo #(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_hilo_if.slave bus
);
    localparam int            CW   = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [CW-1:0]      r_count;
    logic               r_is_div;
    logic               r_neg_res;   // product / quotient must be negated
    logic               r_neg_rem;   // remainder takes the dividend's sign
    logic               r_bzero;
    logic               r_done;
    logic [WIDTH-1:0]   r_opnd;      // multiplicand (mul) or divisor (div), magnitude
    logic [WIDTH-1:0]   r_rem;       // partial remainder (div only)
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [2*WIDTH-1:0] r_prod;      // mul: {acc, multiplier}; div: low half is dividend/quotient

    logic               w_accept;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_abs;
    logic [WIDTH-1:0]   w_b_abs;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_rem_sh;
    logic               w_qbit;
    logic [WIDTH-1:0]   w_rem_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign w_accept = bus.start & ~bus.abort;
    assign w_a_neg  = bus.op[0] & bus.a[WIDTH-1];
    assign w_b_neg  = bus.op[0] & bus.b[WIDTH-1];
    assign w_a_abs  = w_a_neg ? -bus.a : bus.a;
    assign w_b_abs  = w_b_neg ? -bus.b : bus.b;

    // Shift-add step: add multiplicand into the upper half when the current multiplier bit is set.
    assign w_sum = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_opnd} : '0);

    // Restoring step: bring in the next dividend bit, subtract the divisor if it fits.
    // A zero divisor always "fits", yielding all-ones quotient and remainder equal to the dividend.
    assign w_rem_sh   = {r_rem, r_prod[WIDTH-1]};
    assign w_qbit     = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_next = w_qbit ? WIDTH'(w_rem_sh - {1'b0, r_opnd}) : w_rem_sh[WIDTH-1:0];

    assign w_prod_fix = r_neg_res ? -r_prod : r_prod;
    assign w_quo_fix  = r_bzero ? '1 : (r_neg_res ? -r_prod[WIDTH-1:0] : r_prod[WIDTH-1:0]);
    assign w_rem_fix  = r_neg_rem ? -r_rem : r_rem;

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: abort wins over progress in RUN/FIX.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_next = S_RUN;
            S_RUN: begin
                if (bus.abort)            w_state_next = S_IDLE;
                else if (r_count == LAST) w_state_next = S_FIX;
            end
            S_FIX:   w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Datapath: operand latch and MTHI/MTLO in IDLE, one bit per cycle in RUN, sign fix-up in FIX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_is_div  <= 1'b0;
            r_neg_res <= 1'b0;
            r_neg_rem <= 1'b0;
            r_bzero   <= 1'b0;
            r_done    <= 1'b0;
            r_opnd    <= '0;
            r_rem     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_prod    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.we_hi) r_hi <= bus.wd;
                    if (bus.we_lo) r_lo <= bus.wd;
                    if (w_accept) begin
                        r_count   <= '0;
                        r_is_div  <= bus.op[1];
                        r_neg_res <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        r_bzero   <= (bus.b == '0);
                        r_opnd    <= bus.op[1] ? w_b_abs : w_a_abs;
                        r_rem     <= '0;
                        r_prod    <= {{WIDTH{1'b0}}, (bus.op[1] ? w_a_abs : w_b_abs)};
                    end
                end
                S_RUN: begin
                    r_count <= r_count + 1'b1;
                    if (r_is_div) begin
                        r_rem              <= w_rem_next;
                        r_prod[WIDTH-1:0]  <= {r_prod[WIDTH-2:0], w_qbit};
                    end else begin
                        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!bus.abort) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb/tb_muldiv_hilo.sv - self-checking bench for muldiv_hilo with a latency/arithmetic reference model
module tb_muldiv_hilo;
    localparam int WIDTH = 32;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    logic chk_en;

    muldiv_hilo_if #(.WIDTH(WIDTH)) bus ();

    muldiv_hilo #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference result {hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [63:0] ref_calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] r, qv, mv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'b00: r = {32'b0, a} * {32'b0, b};
            2'b01: r = 64'(sa * sb);
            default: begin
                if (b == 32'b0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (op == 2'b10) begin
                    r = {a % b, a / b};
                end else begin
                    q  = sa / sb;
                    m  = sa % sb;
                    qv = 64'(q);
                    mv = 64'(m);
                    r  = {mv[31:0], qv[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Model: an accepted op completes WIDTH+1 edges later unless aborted; MTHI/MTLO only when idle.
    logic [63:0] ref_now;
    logic [63:0] m_res;
    logic [31:0] m_hi, m_lo;
    logic        m_done;
    int          m_left;

    always_comb ref_now = ref_calc(bus.op, bus.a, bus.b);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            m_done <= 1'b0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_left == 0) begin
                if (bus.we_hi) m_hi <= bus.wd;
                if (bus.we_lo) m_lo <= bus.wd;
                if (bus.start && !bus.abort) begin
                    m_res  <= ref_now;
                    m_left <= WIDTH + 1;
                end
            end else if (bus.abort) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model, sampled after the edge settles.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            check("cyc_busy", 64'(bus.busy), 64'(m_left != 0));
            check("cyc_done", 64'(bus.done), 64'(m_done));
            check("cyc_hi",   64'(bus.hi),   64'(m_hi));
            check("cyc_lo",   64'(bus.lo),   64'(m_lo));
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_dir(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
        int lat;
        issue(op, a, b);
        wait_done(lat);
        check({name, "_lat"}, 64'(lat), 64'(WIDTH + 1));
        check({name, "_hi"},  64'(bus.hi), 64'(ehi));
        check({name, "_lo"},  64'(bus.lo), 64'(elo));
    endtask

    initial begin
        int  lat;
        int  r;
        logic saw_done;
        n_checks = 0;
        n_fail   = 0;
        chk_en   = 1'b1;
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.op    = 2'b01;
        bus.a     = 32'd5;
        bus.b     = 32'd3;
        bus.abort = 1'b0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        bus.wd    = '0;

        // Pin the reference model on hand-computed vectors.
        check("ref_mult",  ref_calc(2'b01, 32'hFFFF_FFFD, 32'd5),        64'hFFFF_FFFF_FFFF_FFF1);
        check("ref_multu", ref_calc(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 64'hFFFF_FFFE_0000_0001);
        check("ref_div",   ref_calc(2'b11, 32'hFFFF_FFF9, 32'd2),        64'hFFFF_FFFF_FFFF_FFFD);
        check("ref_divov", ref_calc(2'b11, 32'h8000_0000, 32'hFFFF_FFFF), 64'h0000_0000_8000_0000);
        check("ref_div0",  ref_calc(2'b10, 32'd100, 32'd0),              64'h0000_0064_FFFF_FFFF);
        check("ref_divu",  ref_calc(2'b10, 32'd42, 32'd5),               64'h0000_0002_0000_0008);

        // Reset with start held: nothing runs until release.
        repeat (3) begin
            @(negedge clk);
            check("rst_hi",   64'(bus.hi),   64'h0);
            check("rst_lo",   64'(bus.lo),   64'h0);
            check("rst_busy", 64'(bus.busy), 64'h0);
        end
        rst = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        check("rel_busy", 64'(bus.busy), 64'h1);
        wait_done(lat);
        check("rel_lat", 64'(lat), 64'(WIDTH + 1));
        check("rel_lo",  64'(bus.lo), 64'd15);
        check("rel_hi",  64'(bus.hi), 64'd0);

        run_dir("mult",  2'b01, 32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1);
        run_dir("multu", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_dir("div",   2'b11, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_dir("divov", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000);
        run_dir("div0",  2'b10, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);

        // MTHI, then abort a multiply mid-run with a stray MTLO during RUN.
        @(negedge clk);
        bus.we_hi = 1'b1;
        bus.wd    = 32'h1234;
        @(negedge clk);
        bus.we_hi = 1'b0;
        check("mthi_hi", 64'(bus.hi), 64'h1234);
        issue(2'b00, 32'd7, 32'd6);
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            bus.we_lo = (i == 3);
            bus.wd    = 32'hDEAD_BEEF;
        end
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_busy", 64'(bus.busy), 64'h0);
        check("abort_hi",   64'(bus.hi),   64'h1234);
        check("abort_lo",   64'(bus.lo),   64'hFFFF_FFFF);
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done) saw_done = 1'b1;
        end
        check("abort_nodone", 64'(saw_done), 64'h0);

        // Back-to-back: second op issued in the done cycle of the first.
        issue(2'b00, 32'd7, 32'd6);
        wait_done(lat);
        check("b2b1_lat", 64'(lat), 64'(WIDTH + 1));
        check("b2b1_hi",  64'(bus.hi), 64'd0);
        check("b2b1_lo",  64'(bus.lo), 64'd42);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'd42;
        bus.b     = 32'd5;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b2_busy", 64'(bus.busy), 64'h1);
        wait_done(lat);
        check("b2b2_lat", 64'(lat), 64'(WIDTH + 1));
        check("b2b2_lo",  64'(bus.lo), 64'd8);
        check("b2b2_hi",  64'(bus.hi), 64'd2);

        // Random traffic: ops, corner operands, aborts, stray writes and occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst       = ($urandom_range(0, 599) == 0);
            bus.start = ($urandom_range(0, 3) == 0);
            bus.op    = 2'($urandom_range(0, 3));
            bus.a     = $urandom;
            bus.b     = $urandom;
            r = $urandom_range(0, 15);
            if (r == 0) bus.b = 32'd0;
            else if (r == 1) begin
                bus.a = 32'h8000_0000;
                bus.b = 32'hFFFF_FFFF;
            end else if (r == 2) bus.b = 32'($urandom_range(1, 7));
            else if (r == 3) bus.a = 32'($urandom_range(0, 100));
            bus.abort = ($urandom_range(0, 63) == 0);
            bus.we_hi = ($urandom_range(0, 7) == 0);
            bus.we_lo = ($urandom_range(0, 7) == 0);
            bus.wd    = $urandom;
        end
        @(negedge clk);
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.we_hi = 1'b0;
        bus.we_lo = 1'b0;
        repeat (40) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
